// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the Simple RISC Machine fetch/memory-interface stage.
package fetch_unit_pkg;

    localparam int unsigned AW_DEF      = 9;
    localparam int unsigned TIMEOUT_DEF = 15;
    localparam int unsigned DW          = 16;

    typedef enum logic [1:0] {
        MNONE  = 2'b00,
        MREAD  = 2'b01,
        MWRITE = 2'b10
    } mem_cmd_e;

    typedef enum logic [1:0] {
        F_IDLE = 2'b00,
        F_REQ  = 2'b01,
        F_DONE = 2'b10
    } fetch_state_e;

    // Write-side payload latched at request start
    typedef struct packed {
        logic          we;
        logic [DW-1:0] wdata;
    } mem_wr_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Combinational next-PC select; the PC-relative branch adder exists only
// when FETCH_BRANCH_EN is defined.
module fetch_unit_pc_next
    import fetch_unit_pkg::*;
#(
    parameter int unsigned AW = AW_DEF
) (
    input  logic [AW-1:0] pc,
    input  logic          reset_pc,
`ifdef FETCH_BRANCH_EN
    input  logic          take_branch,
    input  logic [AW-1:0] offset,
`endif
    output logic [AW-1:0] next_pc_c
);

    // reset_pc has priority over a taken branch; all sums wrap mod 2^AW
    always_comb begin
        next_pc_c = pc + AW'(1);
`ifdef FETCH_BRANCH_EN
        if (take_branch) begin
            next_pc_c = pc + AW'(1) + offset;
        end
`endif
        if (reset_pc) begin
            next_pc_c = '0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/memory-interface stage: PC, data-address and instruction registers
// plus the memory handshake FSM. Optional branch support: FETCH_BRANCH_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load_pc,
    input  logic          reset_pc,
    input  logic          addr_sel,
    input  logic          load_addr,
    input  logic          load_ir,
    input  logic [1:0]    mem_cmd,
    input  logic [DW-1:0] datapath_out,
`ifdef FETCH_BRANCH_EN
    input  logic          take_branch,
`endif
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_addr,
    output logic          mem_req,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] ir,
    output logic [2:0]    opcode,
    output logic [1:0]    op,
    output logic [DW-1:0] sximm8,
    output logic          busy,
    output logic          mem_err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    fetch_state_e  state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [AW-1:0] addr_reg;
    logic [AW-1:0] next_pc;
    logic [DW-1:0] rbuf;
    mem_wr_t       wr_q;
    logic          start, done_ok, done_to;

    fetch_unit_pc_next #(
        .AW(AW)
    ) u_pc_next (
        .pc         (pc),
        .reset_pc   (reset_pc),
`ifdef FETCH_BRANCH_EN
        .take_branch(take_branch),
        .offset     (sximm8[AW-1:0]),
`endif
        .next_pc_c  (next_pc)
    );

    // Access FSM: a wait that hits the timeout limit aborts to F_DONE
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        start   = 1'b0;
        done_ok = 1'b0;
        done_to = 1'b0;
        case (state)
            F_IDLE: begin
                if (mem_cmd == MREAD || mem_cmd == MWRITE) begin
                    state_d = F_REQ;
                    cnt_d   = '0;
                    start   = 1'b1;
                end
            end
            F_REQ: begin
                if (mem_ready) begin
                    state_d = F_DONE;
                    done_ok = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_d = F_DONE;
                    done_to = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            F_DONE:  state_d = F_IDLE;
            default: state_d = F_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= F_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            pc       <= '0;
            addr_reg <= '0;
            ir       <= '0;
            rbuf     <= '0;
            mem_addr <= '0;
            wr_q     <= '0;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            cnt <= cnt_d;
            if (load_pc) begin
                pc <= next_pc;
            end
            if (load_addr) begin
                addr_reg <= datapath_out[AW-1:0];
            end
            if (load_ir) begin
                ir <= rbuf;
            end
            // Address tracks the mux only while idle, so it freezes at request start
            if (state == F_IDLE) begin
                mem_addr <= addr_sel ? pc : addr_reg;
            end
            if (start) begin
                wr_q.we    <= (mem_cmd == MWRITE);
                wr_q.wdata <= datapath_out;
                mem_req    <= 1'b1;
                busy       <= 1'b1;
            end
            if (done_ok || done_to) begin
                wr_q.we <= 1'b0;
                mem_req <= 1'b0;
                busy    <= 1'b0;
            end
            if (done_ok && !wr_q.we) begin
                rbuf <= mem_rdata;
            end
            if (done_to) begin
                mem_err <= 1'b1;
            end
        end
    end

    assign mem_we    = wr_q.we;
    assign mem_wdata = wr_q.wdata;
    assign opcode    = ir[15:13];
    assign op        = ir[12:11];
    assign sximm8    = {{8{ir[7]}}, ir[7:0]};

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven reads plus hand-written
// write, PC, timeout and reset sequences.
`timescale 1ns/1ps
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int unsigned AW = 9;
    localparam int unsigned TO = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          load_pc, reset_pc, addr_sel, load_addr, load_ir;
    logic [1:0]    mem_cmd;
    logic [15:0]   datapath_out;
`ifdef FETCH_BRANCH_EN
    logic          take_branch;
`endif
    logic [15:0]   mem_rdata;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic          mem_req, mem_we;
    logic [15:0]   mem_wdata;
    logic [AW-1:0] pc;
    logic [15:0]   ir;
    logic [2:0]    opcode;
    logic [1:0]    op;
    logic [15:0]   sximm8;
    logic          busy, mem_err;

    fetch_unit #(.AW(AW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .load_pc     (load_pc),
        .reset_pc    (reset_pc),
        .addr_sel    (addr_sel),
        .load_addr   (load_addr),
        .load_ir     (load_ir),
        .mem_cmd     (mem_cmd),
        .datapath_out(datapath_out),
`ifdef FETCH_BRANCH_EN
        .take_branch (take_branch),
`endif
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .pc          (pc),
        .ir          (ir),
        .opcode      (opcode),
        .op          (op),
        .sximm8      (sximm8),
        .busy        (busy),
        .mem_err     (mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc_val;
        int            waits;
        logic [15:0]   rdata;
        logic [2:0]    opcode;
        logic [1:0]    op;
        logic [15:0]   sximm8;
    } rd_vec_t;

    rd_vec_t       vecs[4];
    logic [15:0]   sb[$];
    int            tests = 0;
    int            fails = 0;
    logic [AW-1:0] exp_pc;
    logic [15:0]   exp_ir;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_pc(input logic [AW-1:0] v);
        reset_pc = 1'b1;
        load_pc  = 1'b1;
        tick();
        reset_pc = 1'b0;
        for (int i = 0; i < int'(v); i++) tick();
        load_pc = 1'b0;
        exp_pc  = v;
        chk("set_pc", 32'(pc), 32'(exp_pc));
    endtask

    // One access; during REQ the bench scrambles mem_cmd/datapath_out/addr_sel,
    // which the latched access must ignore
    task automatic access(input logic [1:0] cmd, input int waits, input logic [15:0] rdata,
                          input logic [AW-1:0] exp_addr, input logic [15:0] exp_wdata,
                          input bit bump_pc);
        logic exp_we;
        exp_we = (cmd == 2'b10);
        chk("req_idle", 32'(mem_req), 32'(0));
        mem_cmd = cmd;
        tick();
        mem_cmd      = exp_we ? 2'b01 : 2'b10;
        datapath_out = ~datapath_out;
        addr_sel     = ~addr_sel;
        if (bump_pc) load_pc = 1'b1;
        for (int i = 0; i <= waits; i++) begin
            chk("busy", 32'(busy), 32'(1));
            chk("mem_req", 32'(mem_req), 32'(1));
            chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
            chk("mem_we", 32'(mem_we), 32'(exp_we));
            if (exp_we) chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
            mem_ready = (i == waits);
            if (i == waits) begin
                mem_cmd   = 2'b00;
                mem_rdata = rdata;
                if (!exp_we) sb.push_back(rdata);
            end else begin
                mem_rdata = 16'($urandom);
            end
            tick();
            if (bump_pc && i == 0) begin
                load_pc = 1'b0;
                exp_pc  = exp_pc + 9'd1;
            end
        end
        mem_ready = 1'b0;
        chk("busy_fall", 32'(busy), 32'(0));
        chk("req_fall", 32'(mem_req), 32'(0));
        chk("we_fall", 32'(mem_we), 32'(0));
        addr_sel = ~addr_sel;
    endtask

    task automatic do_load_ir();
        load_ir = 1'b1;
        tick();
        load_ir = 1'b0;
    endtask

    task automatic pop_ir();
        chk("sb_size", 32'(sb.size()), 32'(1));
        if (sb.size() > 0) begin
            exp_ir = sb.pop_front();
            chk("ir", 32'(ir), 32'(exp_ir));
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        vecs[0] = '{9'd5,   0, 16'hA0E5, 3'b101, 2'b00, 16'hFFE5};
        vecs[1] = '{9'd17,  2, 16'h6B7F, 3'b011, 2'b01, 16'h007F};
        vecs[2] = '{9'd300, 1, 16'hD880, 3'b110, 2'b11, 16'hFF80};
        vecs[3] = '{9'd0,   0, 16'h3C01, 3'b001, 2'b11, 16'h0001};

        reset = 1'b0;
        {load_pc, reset_pc, addr_sel, load_addr, load_ir} = '0;
        mem_cmd = 2'b00; datapath_out = '0; mem_rdata = '0; mem_ready = 1'b0;
`ifdef FETCH_BRANCH_EN
        take_branch = 1'b0;
`endif
        #1;
        chk("rst_pc", 32'(pc), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_err", 32'(mem_err), 32'(0));
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_req", 32'(mem_req), 32'(0));

        // Table-driven reads
        for (int v = 0; v < 4; v++) begin
            set_pc(vecs[v].pc_val);
            addr_sel = 1'b1;
            access(MREAD, vecs[v].waits, vecs[v].rdata, vecs[v].pc_val, 16'h0, 1'b0);
            do_load_ir();
            pop_ir();
            chk("opcode", 32'(opcode), 32'(vecs[v].opcode));
            chk("op", 32'(op), 32'(vecs[v].op));
            chk("sximm8", 32'(sximm8), 32'(vecs[v].sximm8));
        end

        // Wait-state write with PC load during REQ
        datapath_out = 16'h0012;
        load_addr = 1'b1;
        tick();
        load_addr = 1'b0;
        datapath_out = 16'hBEEF;
        addr_sel = 1'b0;
        access(MWRITE, 3, 16'h5555, 9'h012, 16'hBEEF, 1'b1);
        chk("pc_during_req", 32'(pc), 32'(exp_pc));
        do_load_ir();
        chk("ir_after_write", 32'(ir), 32'(16'h3C01));

        // PC wrap, reset_pc, hold
        set_pc(9'd511);
        load_pc = 1'b1;
        tick();
        load_pc = 1'b0;
        chk("pc_wrap", 32'(pc), 32'(0));
        set_pc(9'd37);
        reset_pc = 1'b1; load_pc = 1'b1;
        tick();
        reset_pc = 1'b0; load_pc = 1'b0;
        chk("pc_reset_pc", 32'(pc), 32'(0));
        set_pc(9'd3);
        tick();
        tick();
        chk("pc_hold", 32'(pc), 32'(3));

`ifdef FETCH_BRANCH_EN
        set_pc(9'd10);
        addr_sel = 1'b1;
        access(MREAD, 0, 16'h00FD, 9'd10, 16'h0, 1'b0);
        do_load_ir();
        pop_ir();
        take_branch = 1'b1; load_pc = 1'b1;
        tick();
        take_branch = 1'b0; load_pc = 1'b0;
        chk("pc_branch", 32'(pc), 32'(8));
        exp_ir = 16'h00FD;
`else
        exp_ir = 16'h3C01;
`endif

        // Timeout: mem_ready never arrives
        set_pc(9'd42);
        addr_sel = 1'b1;
        mem_ready = 1'b0;
        mem_cmd = 2'b01;
        tick();
        mem_cmd = 2'b00;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            mem_rdata = 16'($urandom);
            n++;
            tick();
        end
        chk("timeout_len", 32'(n), 32'(TO));
        chk("timeout_err", 32'(mem_err), 32'(1));
        chk("timeout_busy", 32'(busy), 32'(0));
        do_load_ir();
        chk("timeout_ir", 32'(ir), 32'(exp_ir));

        // Access after timeout still works; error stays sticky
        access(MREAD, 0, 16'h1234, 9'd42, 16'h0, 1'b0);
        do_load_ir();
        pop_ir();
        chk("err_sticky", 32'(mem_err), 32'(1));

        // Asynchronous reset in the middle of a write
        datapath_out = 16'hFFFF;
        mem_cmd = 2'b10;
        tick();
        mem_cmd = 2'b00;
        chk("pre_rst_busy", 32'(busy), 32'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'(0));
        chk("arst_we", 32'(mem_we), 32'(0));
        chk("arst_busy", 32'(busy), 32'(0));
        chk("arst_err", 32'(mem_err), 32'(0));
        chk("arst_ir", 32'(ir), 32'(0));
        chk("arst_addr", 32'(mem_addr), 32'(0));
        chk("arst_wdata", 32'(mem_wdata), 32'(0));
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("rel_pc", 32'(pc), 32'(0));
        chk("rel_req", 32'(mem_req), 32'(0));
        chk("rel_busy", 32'(busy), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch and memory-interface stage for the Simple RISC Machine.
- Holds the program counter, data-address register and instruction register, and runs the handshake with memory.
- Sits directly upstream of the control FSM: supplies `opcode`/`op` for decode and consumes the FSM's `load_ir`, `load_addr`, `load_pc`, `reset_pc`, `addr_sel` and `mem_cmd`.
- Raises `busy` while a memory access is outstanding so the FSM can hold its state.

## Interface
- `AW`, 9: address width (PC, data address, memory address).
- `TIMEOUT`, 15: maximum wait cycles for `mem_ready` before abort.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-low; asserted when 0.
- `load_pc`  in  1  PC register enable.
- `reset_pc`  in  1  next-PC mux selects 0.
- `addr_sel`  in  1  1: `mem_addr` = PC; 0: `mem_addr` = data-address register.
- `load_addr`  in  1  data-address register loads `datapath_out[AW-1:0]`.
- `load_ir`  in  1  IR loads the read buffer.
- `mem_cmd`  in  2  00 none, 01 MREAD, 10 MWRITE; 11 treated as none.
- `datapath_out`  in  16  datapath result (address and write data).
- `take_branch`  in  1  branch taken; present only with `FETCH_BRANCH_EN`.
- `mem_rdata`  in  16  memory read data, valid when `mem_ready` = 1.
- `mem_ready`  in  1  memory completes the current access.
- `mem_addr`  out  AW  memory address.
- `mem_req`  out  1  access request.
- `mem_we`  out  1  1 = write.
- `mem_wdata`  out  16  write data.
- `pc`  out  AW  current PC.
- `ir`  out  16  instruction register.
- `opcode`  out  3  `ir[15:13]`.
- `op`  out  2  `ir[12:11]`.
- `sximm8`  out  16  `ir[7:0]` sign-extended.
- `busy`  out  1  access outstanding; control FSM holds.
- `mem_err`  out  1  sticky timeout flag.

## Operation
- Reset (asynchronous, while `reset` = 0): `pc`, `ir`, data-address register, read buffer and timeout counter = 0; FSM = F_IDLE; `mem_req`, `mem_we`, `busy`, `mem_err` = 0.
- Next-PC:
  - `reset_pc` = 1: next-PC = 0.
  - else if `FETCH_BRANCH_EN` and `take_branch` = 1: next-PC = `pc + 1 + sximm8[AW-1:0]`.
  - else: next-PC = `pc + 1`.
  - All next-PC arithmetic is mod 2^AW; 511 + 1 wraps to 0.
- `pc` updates only when `load_pc` = 1.
- `mem_addr` is `addr_sel ? pc : addr_reg`. It is sampled into an internal latch at request start and held stable until completion.
- FSM states:
  - F_IDLE: `mem_cmd` ∈ {01, 10} → F_REQ. Latch address; latch `mem_we` = (`mem_cmd` == 10); latch `mem_wdata` = `datapath_out`.
  - F_REQ: `mem_req` = 1, `busy` = 1.
    - `mem_ready` → F_DONE. On a read, the read buffer captures `mem_rdata`.
    - Timeout counter reaches `TIMEOUT` → F_DONE with `mem_err` set. The read buffer is unchanged.
  - F_DONE: `busy` = 0, `mem_req` = 0 → F_IDLE.
- `load_ir` = 1 copies the read buffer to `ir` on any cycle. The FSM issues it in the cycle after `busy` falls.
- `mem_cmd` changes while in F_REQ are ignored; the latched command completes.
- `mem_err` is cleared only by reset.

## Timing
- `mem_req` rises 1 cycle after `mem_cmd` is asserted in F_IDLE.
- With zero wait states (`mem_ready` high in the first F_REQ cycle), `busy` is high for exactly 1 cycle and the read buffer is valid at the F_DONE edge.
- Each cycle with `mem_ready` low adds 1 cycle to the access.
- Back-to-back accesses: minimum 3 cycles per access (IDLE, REQ, DONE).
- `load_pc`, `load_addr` and `load_ir` act in the same cycle as F_REQ and do not disturb the latched access.
- `opcode`, `op` and `sximm8` are combinational from `ir`: valid 0 cycles after `ir` updates.

## Configuration
- `FETCH_BRANCH_EN` defined:
  - `take_branch` port exists.
  - PC-relative branch adder is included.
- `FETCH_BRANCH_EN` undefined:
  - No `take_branch` port.
  - Next-PC is only 0 or `pc + 1`.

## Structure
- Shared package holds:
  - `mem_cmd` encodings (MNONE, MREAD, MWRITE).
  - FSM state encoding (F_IDLE, F_REQ, F_DONE).
  - Default `AW` and `TIMEOUT`.
- One sub-module: `pc_next`, the combinational next-PC mux plus branch adder; its branch path is gated by `FETCH_BRANCH_EN`.

## Test plan
- Reset: hold `reset` = 0 mid-access → all outputs 0, FSM in F_IDLE; `pc` = 0 after release.
- Zero-wait read: `addr_sel` = 1, `pc` = 5, `mem_cmd` = 01, `mem_ready` = 1, `mem_rdata` = 0xA0E5 → `busy` high 1 cycle; after `load_ir`, `opcode` = 101, `op` = 00, `sximm8` = 0xFFE5.
- Wait-state write: `load_addr` with `datapath_out` = 0x0012, `addr_sel` = 0, `mem_cmd` = 10, `mem_ready` delayed 3 cycles → `mem_addr` = 0x012 and `mem_we` = 1 held for 4 cycles; `mem_wdata` stable throughout.
- PC: `load_pc` at `pc` = 511 → `pc` = 0; `reset_pc` + `load_pc` → 0.
- Branch (`FETCH_BRANCH_EN`): `pc` = 10, `sximm8` = −3, `take_branch` + `load_pc` → `pc` = 8.
- Timeout: `mem_ready` held 0 → `mem_err` = 1 after `TIMEOUT` cycles, `busy` falls, `ir` unchanged.
